// File: rtl/key_filter_multi.sv
// Multi-channel key debouncer: per channel a 2-flop synchroniser feeding a press/release
// debounce FSM that emits press, release and long-press pulses plus a debounced level.
// Optional auto-repeat after a long press is enabled by defining KEY_REPEAT_EN.
module key_filter_multi #(
  parameter int          KEY_NUM        = 4,
  parameter int          KEY_ACTIVE_LOW = 1,
  parameter int unsigned CNT_MAX        = 20'd999_999,
  parameter int unsigned LONG_MAX       = 26'd49_999_999,
  parameter int unsigned REPEAT_MAX     = 24'd9_999_999
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long
);

  localparam int DB_W   = (CNT_MAX  > 0) ? $clog2(CNT_MAX + 1)  : 1;
  localparam int HOLD_W = (LONG_MAX > 0) ? $clog2(LONG_MAX + 1) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(CNT_MAX);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_MAX);
  localparam logic              IDLE_LVL  = (KEY_ACTIVE_LOW != 0);

`ifdef KEY_REPEAT_EN
  localparam int RPT_W = (REPEAT_MAX > 0) ? $clog2(REPEAT_MAX + 1) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_MAX);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P_DB = 2'd1,
    HELD = 2'd2,
    R_DB = 2'd3
  } state_t;

  function automatic logic [HOLD_W-1:0] hold_sat_inc(input logic [HOLD_W-1:0] v);
    return (v == HOLD_LAST) ? v : v + 1'b1;
  endfunction

  for (genvar g = 0; g < KEY_NUM; g++) begin : g_ch
    state_t            st_q;
    logic [1:0]        sync_q;
    logic [DB_W-1:0]   db_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;
    logic              state_q;
    logic              press_q;
    logic              release_q;
    logic              long_q;
    logic              act;
`ifdef KEY_REPEAT_EN
    logic [RPT_W-1:0]  rpt_cnt_q;
`endif

    // act is 1 while the synchronised key reads as pressed
    assign act        = sync_q[1] ^ IDLE_LVL;
    assign hold_cnt_d = hold_sat_inc(hold_cnt_q);

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        sync_q     <= {2{IDLE_LVL}};
        st_q       <= IDLE;
        db_cnt_q   <= '0;
        hold_cnt_q <= '0;
        state_q    <= 1'b0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        long_q     <= 1'b0;
`ifdef KEY_REPEAT_EN
        rpt_cnt_q  <= '0;
`endif
      end else begin
        sync_q    <= {sync_q[0], key_in[g]};
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        case (st_q)
          IDLE: begin
            if (act) begin
              st_q     <= P_DB;
              db_cnt_q <= '0;
`ifdef KEY_REPEAT_EN
              rpt_cnt_q <= '0;
`endif
            end
          end
          P_DB: begin
            if (!act) begin
              st_q     <= IDLE;
              db_cnt_q <= '0;
            end else if (db_cnt_q == DB_LAST) begin
              st_q       <= HELD;
              press_q    <= 1'b1;
              state_q    <= 1'b1;
              hold_cnt_q <= '0;
            end else begin
              db_cnt_q <= db_cnt_q + 1'b1;
            end
          end
          HELD: begin
            if (!act) begin
              st_q     <= R_DB;
              db_cnt_q <= '0;
            end else begin
              hold_cnt_q <= hold_cnt_d;
              // fires only on the transition into saturation, so once per press
              if (hold_cnt_q != HOLD_LAST && hold_cnt_d == HOLD_LAST) begin
                long_q <= 1'b1;
              end
`ifdef KEY_REPEAT_EN
              if (hold_cnt_q == HOLD_LAST) begin
                if (rpt_cnt_q == RPT_LAST) begin
                  rpt_cnt_q <= '0;
                  press_q   <= 1'b1;
                end else begin
                  rpt_cnt_q <= rpt_cnt_q + 1'b1;
                end
              end
`endif
            end
          end
          R_DB: begin
            if (act) begin
              st_q     <= HELD;
              db_cnt_q <= '0;
            end else if (db_cnt_q == DB_LAST) begin
              st_q      <= IDLE;
              release_q <= 1'b1;
              state_q   <= 1'b0;
            end else begin
              db_cnt_q <= db_cnt_q + 1'b1;
            end
          end
          default: st_q <= IDLE;
        endcase
      end
    end

    assign key_state[g]   = state_q;
    assign key_press[g]   = press_q;
    assign key_release[g] = release_q;
    assign key_long[g]    = long_q;
  end

endmodule
